// File: rtl/deser_pkg.sv
// deser_pkg
//   Shared types and widths for the serial-to-parallel deserializer.
//   WORD_W  : width of an assembled word
//   LEN_W   : width of the valid-bit count that goes with each word (1..16)
//   state_t : collection FSM states
//   entry_t : one output buffer entry {data, len}
package deser_pkg;

    localparam int WORD_W = 16;
    localparam int LEN_W  = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } entry_t;

endpackage

// File: rtl/deser_fifo.sv
// deser_fifo
//   Output buffer for completed frames. The head entry is presented
//   combinationally and reads as zero while the buffer is empty.
//   FIFO_DEPTH must be a power of two and at least 2.
// Ports:
//   clk_i      - clock, rising edge
//   arstn_i    - asynchronous active-low reset, empties the buffer
//   wr_en_i    - write request
//   wr_data_i  - entry to write
//   rd_en_i    - pop request, ignored while empty
//   rd_data_o  - head entry
//   full_o     - buffer holds FIFO_DEPTH entries
//   empty_o    - buffer holds no entries
module deser_fifo
    import deser_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic   clk_i,
    input  logic   arstn_i,
    input  logic   wr_en_i,
    input  entry_t wr_data_i,
    input  logic   rd_en_i,
    output entry_t rd_data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_rd;
    logic              do_wr;

    // A write into a full buffer is still accepted when a pop frees the
    // head slot on the same edge.
    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    assign full_o    = (count == CNT_W'(FIFO_DEPTH));
    assign empty_o   = (count == '0);
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

endmodule

// File: rtl/deserializer.sv
// deserializer
//   Collects MSB-first serial bits into left-aligned 16-bit words. A
//   contiguous run of ser_data_val_i forms a frame; runs longer than 16
//   bits are split into 16-bit frames. Completed frames go to a buffer;
//   when the buffer is full (and not popping) the frame is dropped and
//   overflow_o pulses for one cycle.
// Ports:
//   clk_i          - clock, rising edge
//   arstn_i        - asynchronous active-low reset
//   ser_data_i     - serial data bit
//   ser_data_val_i - serial bit valid
//   deser_data_o   - head word, first received bit in [15]
//   deser_len_o    - valid bits in deser_data_o
//   deser_val_o    - head word valid
//   deser_rdy_i    - consumer ready
//   overflow_o     - one-cycle pulse after a dropped frame
module deserializer
    import deser_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [WORD_W-1:0] deser_data_o,
    output logic [LEN_W-1:0]  deser_len_o,
    output logic              deser_val_o,
    input  logic              deser_rdy_i,
    output logic              overflow_o
);

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;
    logic [LEN_W-1:0]  count_q;
    logic [LEN_W-1:0]  count_d;
    logic              commit;
    entry_t            commit_entry;
    entry_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              overflow_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // The shift register only ever has zeros below the current bit position,
    // so each new bit is OR-ed into its slot. The 16th bit is merged straight
    // into the committed word, leaving the FSM free to start the next frame
    // on the following edge.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        count_d      = count_q;
        commit       = 1'b0;
        commit_entry = '0;
        unique case (state_q)
            IDLE: begin
                if (ser_data_val_i) begin
                    shift_d = {ser_data_i, {(WORD_W-1){1'b0}}};
                    count_d = LEN_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!ser_data_val_i) begin
                    commit            = 1'b1;
                    commit_entry.data = shift_q;
                    commit_entry.len  = count_q;
                    shift_d           = '0;
                    count_d           = '0;
                    state_d           = IDLE;
                end else if (count_q == LEN_W'(WORD_W-1)) begin
                    commit            = 1'b1;
                    commit_entry.data = shift_q | WORD_W'(ser_data_i);
                    commit_entry.len  = LEN_W'(WORD_W);
                    shift_d           = '0;
                    count_d           = '0;
                    state_d           = IDLE;
                end else begin
                    shift_d = shift_q | (WORD_W'(ser_data_i) << (LEN_W'(WORD_W-1) - count_q));
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pop = ~fifo_empty & deser_rdy_i;

    // A pop on the commit edge frees a slot, so only a full buffer with no
    // pop drops the frame.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= commit & fifo_full & ~pop;
        end
    end

    deser_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .wr_en_i   (commit),
        .wr_data_i (commit_entry),
        .rd_en_i   (deser_rdy_i),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign deser_data_o = head.data;
    assign deser_len_o  = head.len;
    assign deser_val_o  = ~fifo_empty;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer
//   Directed bench for deserializer. Expected words are queued when a frame
//   is sent and compared whenever the DUT pops a word.
module tb_deserializer;
    import deser_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        ser_data_i;
    logic        ser_data_val_i;
    logic [15:0] deser_data_o;
    logic [4:0]  deser_len_o;
    logic        deser_val_o;
    logic        deser_rdy_i;
    logic        overflow_o;

    int     checks = 0;
    int     errors = 0;
    int     ovf_cycles = 0;
    int     ovf_base;
    entry_t exp_q[$];

    logic [31:0] fr_bits [5] = '{32'h5, 32'h4B, 32'hBEEF, 32'h1, 32'h1A3};
    int          fr_len  [5] = '{3, 7, 16, 1, 9};

    deserializer #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .ser_data_i     (ser_data_i),
        .ser_data_val_i (ser_data_val_i),
        .deser_data_o   (deser_data_o),
        .deser_len_o    (deser_len_o),
        .deser_val_o    (deser_val_o),
        .deser_rdy_i    (deser_rdy_i),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (overflow_o === 1'b1) begin
            ovf_cycles++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one serial cycle; if the DUT is about to pop, compare its head
    // word against the scoreboard first.
    task automatic applyStimulus(input logic val, input logic bit_v);
        entry_t e;
        ser_data_val_i = val;
        ser_data_i     = bit_v;
        if (deser_val_o === 1'b1 && deser_rdy_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", 32'(deser_val_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pop_data", 32'(deser_data_o), 32'(e.data));
                checkOutput("pop_len", 32'(deser_len_o), 32'(e.len));
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic sendBits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, bits[n-1-i]);
        end
    endtask

    task automatic pushFrame(input logic [31:0] bits, input int n);
        entry_t      e;
        logic [31:0] aligned;
        aligned = bits << (16 - n);
        e.data  = aligned[15:0];
        e.len   = 5'(n);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0);
        end
    endtask

    initial begin
        arstn_i        = 1'b0;
        ser_data_i     = 1'b0;
        ser_data_val_i = 1'b0;
        deser_rdy_i    = 1'b0;
        #1;
        checkOutput("reset_data", 32'(deser_data_o), 32'd0);
        checkOutput("reset_len", 32'(deser_len_o), 32'd0);
        checkOutput("reset_val", 32'(deser_val_o), 32'd0);
        checkOutput("reset_ovf", 32'(overflow_o), 32'd0);
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        idle(2);

        // Full 16-bit frame; word appears right after the 16th bit edge.
        $display("[TB] 16-bit frame 0xA5C3");
        pushFrame(32'hA5C3, 16);
        sendBits(32'hA5C3 >> 1, 15);
        checkOutput("w16_not_yet", 32'(deser_val_o), 32'd0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("w16_val", 32'(deser_val_o), 32'd1);
        checkOutput("w16_data", 32'(deser_data_o), 32'hA5C3);
        checkOutput("w16_len", 32'(deser_len_o), 32'd16);
        deser_rdy_i = 1'b1;
        idle(1);
        checkOutput("w16_drained", 32'(deser_val_o), 32'd0);

        // Short frame committed on the val-low edge.
        $display("[TB] 5-bit frame");
        deser_rdy_i = 1'b0;
        pushFrame(32'b10110, 5);
        sendBits(32'b10110, 5);
        checkOutput("w5_not_yet", 32'(deser_val_o), 32'd0);
        idle(1);
        checkOutput("w5_val", 32'(deser_val_o), 32'd1);
        checkOutput("w5_data", 32'(deser_data_o), 32'hB000);
        checkOutput("w5_len", 32'(deser_len_o), 32'd5);
        deser_rdy_i = 1'b1;
        idle(2);

        // 20-bit run splits into 16 + 4.
        $display("[TB] 20-bit run");
        pushFrame(32'hABCD, 16);
        pushFrame(32'hE, 4);
        sendBits(32'hABCDE, 20);
        idle(3);
        checkOutput("run20_all_popped", 32'(exp_q.size()), 32'd0);
        checkOutput("run20_empty", 32'(deser_val_o), 32'd0);

        // Five frames into a depth-4 buffer with the consumer stalled.
        $display("[TB] overflow");
        deser_rdy_i = 1'b0;
        ovf_base    = ovf_cycles;
        for (int f = 0; f < 5; f++) begin
            if (f < DEPTH) begin
                pushFrame(fr_bits[f], fr_len[f]);
            end
            sendBits(fr_bits[f], fr_len[f]);
            idle(1);
        end
        idle(2);
        checkOutput("ovf_pulses", 32'(ovf_cycles - ovf_base), 32'd1);
        checkOutput("ovf_hold_val", 32'(deser_val_o), 32'd1);
        checkOutput("ovf_hold_data", 32'(deser_data_o), 32'hA000);
        deser_rdy_i = 1'b1;
        idle(6);
        checkOutput("ovf_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("ovf_empty", 32'(deser_val_o), 32'd0);

        // Commit coinciding with a pop on a full buffer.
        $display("[TB] commit with pop while full");
        deser_rdy_i = 1'b0;
        ovf_base    = ovf_cycles;
        for (int f = 0; f < DEPTH; f++) begin
            pushFrame(fr_bits[f], fr_len[f]);
            sendBits(fr_bits[f], fr_len[f]);
            idle(1);
        end
        pushFrame(32'h1A3, 9);
        sendBits(32'h1A3, 9);
        deser_rdy_i = 1'b1;
        idle(1);
        checkOutput("cp_val", 32'(deser_val_o), 32'd1);
        idle(6);
        checkOutput("cp_no_ovf", 32'(ovf_cycles - ovf_base), 32'd0);
        checkOutput("cp_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame with a word waiting in the buffer.
        $display("[TB] reset mid-frame");
        deser_rdy_i = 1'b0;
        sendBits(32'h1234, 16);
        sendBits(32'h55, 7);
        checkOutput("pre_rst_val", 32'(deser_val_o), 32'd1);
        #2;
        arstn_i = 1'b0;
        #1;
        checkOutput("rst_data", 32'(deser_data_o), 32'd0);
        checkOutput("rst_len", 32'(deser_len_o), 32'd0);
        checkOutput("rst_val", 32'(deser_val_o), 32'd0);
        checkOutput("rst_ovf", 32'(overflow_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        arstn_i     = 1'b1;
        deser_rdy_i = 1'b1;
        idle(2);
        checkOutput("post_rst_empty", 32'(deser_val_o), 32'd0);
        pushFrame(32'h3C5, 12);
        sendBits(32'h3C5, 12);
        idle(3);
        checkOutput("post_rst_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("total_ovf", 32'(ovf_cycles), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, minimum 2.
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 arstn_i  input  1  reset, asynchronous assert, active-low.
REQ-004 ser_data_i  input  1  serial bit, MSB first; sampled only when ser_data_val_i=1.
REQ-005 ser_data_val_i  input  1  bit-valid; a contiguous high run forms one frame.
REQ-006 deser_data_o  output  16  assembled word; first received bit in [15], unused LSBs zero.
REQ-007 deser_len_o  output  5  number of valid bits in deser_data_o, 1..16.
REQ-008 deser_val_o  output  1  head-of-buffer word valid.
REQ-009 deser_rdy_i  input  1  consumer ready; pop on deser_val_o & deser_rdy_i.
REQ-010 overflow_o  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-011 FSM states IDLE, COLLECT; leaves IDLE on the first edge with ser_data_val_i=1.
REQ-012 IDLE with val=1: shift register loaded with bit in [15], rest zero; bit count set to 1; go to COLLECT.
REQ-013 COLLECT with val=1 and count<15: next bit stored at position 15-count; count increments.
REQ-014 COLLECT with val=1 and count=15: 16th bit stored at [0]; frame committed with len=16 on the same edge; go to IDLE.
REQ-015 COLLECT with val=0: frame committed with len=count on that edge; go to IDLE.
REQ-016 A val run longer than 16 bits is split. The bit after a 16-bit commit starts a new frame with count=1, with no gap needed.
REQ-017 Commit writes {word,len} to the FIFO when it is not full. The entry is visible on deser_val_o/deser_data_o/deser_len_o the cycle after the commit edge.
REQ-018 Commit when the FIFO is full and there is no pop on the same edge: the frame is dropped, overflow_o=1 for exactly one cycle, and FIFO contents are unchanged.
REQ-019 Commit and pop on the same edge with FIFO full: the write succeeds and there is no overflow.
REQ-020 Pop with FIFO empty is ignored. deser_val_o = not empty. Outputs hold stable while deser_val_o=1 and deser_rdy_i=0.
REQ-021 FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are tracked by an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-022 Throughput: one bit per clock accepted continuously. Collection never stalls on the output side; only drops occur.
REQ-023 ser_data_i is ignored when ser_data_val_i=0.

Reset
REQ-024 arstn_i low asynchronously forces: FSM=IDLE, count=0, shift register=0, FIFO empty, deser_val_o=0, deser_data_o=0, deser_len_o=0, overflow_o=0.
REQ-025 Reset during COLLECT discards the partial frame. Nothing is committed and overflow_o is not pulsed.
REQ-026 After arstn_i deasserts, the first edge with val=1 starts a new frame.

Structure
REQ-027 Package deser_pkg holds WORD_W=16, LEN_W=5, the FSM state enum type, and the FIFO entry struct {data[15:0], len[4:0]}.
REQ-028 Sub-module deser_fifo (parameter FIFO_DEPTH, entry type from deser_pkg) implements the storage, pointers, count and full/empty.
REQ-029 The top level contains the FSM, the shift register, the bit counter and the overflow logic only.

Verification
REQ-030 Send 16 bits 0xA5C3 with val high for 16 cycles -> one word data=0xA5C3, len=16, deser_val_o rises one cycle after the 16th bit edge.
REQ-031 Send 5 bits 1,0,1,1,0, then val low -> data=0xB000, len=5; commit occurs on the val-low edge.
REQ-032 Send a 20-bit continuous run -> two words: first 16 bits with len=16, then the last 4 bits left-aligned with len=4.
REQ-033 Hold deser_rdy_i=0 and send 5 frames with FIFO_DEPTH=4 -> 4 words are retained in order, the 5th is dropped, and overflow_o pulses once. Then raising rdy drains exactly 4 words.
REQ-034 FIFO full and a commit coincides with a pop -> no overflow, and the new word appears last in order.
REQ-035 Assert arstn_i low mid-frame after 7 bits -> all outputs are 0 immediately, no word is emitted, and a frame sent after release is received correctly.
